// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dmem arbiter: FSM state encoding and the
// requester identifiers used for grant/owner tracking.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic P_ID = 1'b0;
  localparam logic L_ID = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-input round-robin picker.
//   p_req, l_req : active requests
//   last_owner   : requester granted most recently (P_ID / L_ID)
//   grant_valid  : at least one request is active
//   grant_id     : chosen requester; on a tie the one that is not last_owner
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic p_req,
  input  logic l_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = p_req | l_req;
    grant_id    = P_ID;
    if (p_req && l_req) begin
      grant_id = ~last_owner;
    end else if (l_req) begin
      grant_id = L_ID;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous dmem between the processor
// port (P) and the loader/debug port (L) with a req/ack handshake per port.
//   clock, reset        : clock, asynchronous active-low reset
//   p_* / l_*           : requester ports (req held until ack; ack is a
//                         one-cycle pulse, rdata valid with the ack)
//   mem_addr/data/wren  : to dmem;  mem_q : dmem read data (RD_LAT cycles)
//   busy                : FSM not in IDLE
//   owner               : current/last grant (0 = P, 1 = L)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW     = 12,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          p_req,
  input  logic          p_wren,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_ack,
  output logic [DW-1:0] p_rdata,
  input  logic          l_req,
  input  logic          l_wren,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
  output logic [DW-1:0] l_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic          busy,
  output logic          owner
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  arb_state_e    state, state_nxt;
  logic [2:0]    lat_cnt;
  logic          wren_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] p_rdata_q, l_rdata_q;
  logic          grant_valid, grant_id;

  rr_pick2 u_pick (
    .p_req      (p_req),
    .l_req      (l_req),
    .last_owner (owner),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = (wren_q || RD_LAT == 1) ? RESP : WAIT;
      WAIT:    if (lat_cnt == 3'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      owner     <= L_ID;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      p_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner   <= grant_id;
            wren_q  <= (grant_id == L_ID) ? l_wren  : p_wren;
            addr_q  <= (grant_id == L_ID) ? l_addr  : p_addr;
            wdata_q <= (grant_id == L_ID) ? l_wdata : p_wdata;
          end
        end
        ISSUE: begin
          if (!wren_q) lat_cnt <= LAT_LOAD;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
        end
        RESP: begin
          if (!wren_q) begin
            if (owner == L_ID) l_rdata_q <= mem_q;
            else               p_rdata_q <= mem_q;
          end
        end
        default: ;
      endcase
    end
  end

  // The request registers double as the dmem address/data drivers, so they
  // naturally hold their last values outside a transaction.
  assign mem_addr = addr_q;
  assign mem_data = wdata_q;
  assign mem_wren = (state == ISSUE) && wren_q;
  assign busy     = (state != IDLE);
  assign p_ack    = (state == RESP) && (owner == P_ID);
  assign l_ack    = (state == RESP) && (owner == L_ID);

  // mem_q is forwarded during the ack cycle so rdata is valid with the ack;
  // the register keeps it afterwards.
  assign p_rdata = (p_ack && !wren_q) ? mem_q : p_rdata_q;
  assign l_rdata = (l_ack && !wren_q) ? mem_q : l_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        p_req   [2];
  logic        p_wren  [2];
  logic [11:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic        p_ack   [2];
  logic [31:0] p_rdata [2];
  logic        l_req   [2];
  logic        l_wren  [2];
  logic [11:0] l_addr  [2];
  logic [31:0] l_wdata [2];
  logic        l_ack   [2];
  logic [31:0] l_rdata [2];
  logic [11:0] mem_addr[2];
  logic [31:0] mem_data[2];
  logic        mem_wren[2];
  logic [31:0] mem_q   [2];
  logic        busy    [2];
  logic        owner   [2];

  int checks = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3; each has its own dmem.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem  [0:4095];
    logic [31:0] pipe [0:LAT-1];

    dmem_arbiter #(.AW(12), .DW(32), .RD_LAT(LAT)) u_dut (
      .clock   (clock),
      .reset   (reset),
      .p_req   (p_req[g]),
      .p_wren  (p_wren[g]),
      .p_addr  (p_addr[g]),
      .p_wdata (p_wdata[g]),
      .p_ack   (p_ack[g]),
      .p_rdata (p_rdata[g]),
      .l_req   (l_req[g]),
      .l_wren  (l_wren[g]),
      .l_addr  (l_addr[g]),
      .l_wdata (l_wdata[g]),
      .l_ack   (l_ack[g]),
      .l_rdata (l_rdata[g]),
      .mem_addr(mem_addr[g]),
      .mem_data(mem_data[g]),
      .mem_wren(mem_wren[g]),
      .mem_q   (mem_q[g]),
      .busy    (busy[g]),
      .owner   (owner[g])
    );

    initial for (int i = 0; i < 4096; i++) mem[i] = '0;

    always @(posedge clock) begin
      if (mem_wren[g]) mem[mem_addr[g]] <= mem_data[g];
      pipe[0] <= mem[mem_addr[g]];
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign mem_q[g] = pipe[LAT-1];
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One handshake from IDLE: drive the request, wait (bounded) for the ack,
  // then drop req and step into the following IDLE cycle.
  task automatic access(input int d, input bit side, input logic wr,
                        input logic [11:0] addr, input logic [31:0] wd,
                        output int lat, output int wr_cnt,
                        output logic [11:0] wr_addr, output logic [31:0] rd,
                        output int other);
    lat = 0; wr_cnt = 0; wr_addr = '0; rd = '0; other = 0;
    if (side) begin
      l_req[d] = 1'b1; l_wren[d] = wr; l_addr[d] = addr; l_wdata[d] = wd;
    end else begin
      p_req[d] = 1'b1; p_wren[d] = wr; p_addr[d] = addr; p_wdata[d] = wd;
    end
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (mem_wren[d] === 1'b1) begin
        wr_cnt++;
        wr_addr = mem_addr[d];
      end
      if ((side ? p_ack[d] : l_ack[d]) === 1'b1) other++;
      if ((side ? l_ack[d] : p_ack[d]) === 1'b1) begin
        lat = n;
        rd  = side ? l_rdata[d] : p_rdata[d];
        break;
      end
    end
    if (side) l_req[d] = 1'b0;
    else      p_req[d] = 1'b0;
    tick();
  endtask

  int          lat, wr_cnt, other, nacks, both, n0;
  logic [11:0] wr_addr;
  logic [31:0] rd;
  logic [3:0]  seq;

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      p_req[d] = 1'b0; p_wren[d] = 1'b0; p_addr[d] = '0; p_wdata[d] = '0;
      l_req[d] = 1'b0; l_wren[d] = 1'b0; l_addr[d] = '0; l_wdata[d] = '0;
    end
    repeat (3) tick();

    // Reset state
    check("rst_p_ack",    32'(p_ack[0]),    32'd0);
    check("rst_l_ack",    32'(l_ack[0]),    32'd0);
    check("rst_mem_wren", 32'(mem_wren[0]), 32'd0);
    check("rst_busy",     32'(busy[0]),     32'd0);
    check("rst_owner",    32'(owner[0]),    32'd1);
    check("rst_mem_addr", 32'(mem_addr[0]), 32'd0);
    check("rst_mem_data", mem_data[0],      32'd0);
    check("rst_p_rdata",  p_rdata[0],       32'd0);
    check("rst_l_rdata",  l_rdata[0],       32'd0);
    check("rst_owner_b",  32'(owner[1]),    32'd1);
    reset = 1'b1;
    tick();

    // P write 0x010 = DEADBEEF (RD_LAT=1 instance)
    access(0, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, lat, wr_cnt, wr_addr, rd, other);
    check("wr_lat",      32'(lat),     32'd2);
    check("wr_wren_cnt", 32'(wr_cnt),  32'd1);
    check("wr_addr",     32'(wr_addr), 32'h010);
    check("wr_l_ack",    32'(other),   32'd0);

    // P read 0x010, RD_LAT=1
    access(0, 1'b0, 1'b0, 12'h010, 32'h0, lat, wr_cnt, wr_addr, rd, other);
    check("rd1_lat",     32'(lat),    32'd2);
    check("rd1_data",    rd,          32'hDEADBEEF);
    check("rd1_no_wren", 32'(wr_cnt), 32'd0);

    // Same on the RD_LAT=3 instance
    access(1, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, lat, wr_cnt, wr_addr, rd, other);
    check("wr3_lat", 32'(lat), 32'd2);
    access(1, 1'b0, 1'b0, 12'h010, 32'h0, lat, wr_cnt, wr_addr, rd, other);
    check("rd3_lat",  32'(lat), 32'd4);
    check("rd3_data", rd,       32'hDEADBEEF);

    // Loader read, loader write to top address, processor reads it back
    access(0, 1'b1, 1'b0, 12'h010, 32'h0, lat, wr_cnt, wr_addr, rd, other);
    check("l_rd_lat",  32'(lat), 32'd2);
    check("l_rd_data", rd,       32'hDEADBEEF);
    check("l_owner",   32'(owner[0]), 32'd1);
    access(0, 1'b1, 1'b1, 12'hFFF, 32'h1, lat, wr_cnt, wr_addr, rd, other);
    check("l_wr_lat",  32'(lat),     32'd2);
    check("l_wr_addr", 32'(wr_addr), 32'hFFF);
    check("l_wr_rdata_kept", l_rdata[0], 32'hDEADBEEF);
    access(0, 1'b0, 1'b0, 12'hFFF, 32'h0, lat, wr_cnt, wr_addr, rd, other);
    check("p_rd_fff",         rd,          32'h1);
    check("l_rdata_unchanged", l_rdata[0], 32'hDEADBEEF);
    check("p_owner",           32'(owner[0]), 32'd0);

    // Reset, then both requesters hold req continuously
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    p_req[0] = 1'b1; p_wren[0] = 1'b0; p_addr[0] = 12'h010;
    l_req[0] = 1'b1; l_wren[0] = 1'b0; l_addr[0] = 12'hFFF;
    seq = '0; nacks = 0; both = 0;
    for (int n = 0; n < 40 && nacks < 4; n++) begin
      tick();
      if (p_ack[0] === 1'b1 && l_ack[0] === 1'b1) both++;
      if (p_ack[0] === 1'b1) begin
        seq = {seq[2:0], 1'b0}; nacks++;
      end else if (l_ack[0] === 1'b1) begin
        seq = {seq[2:0], 1'b1}; nacks++;
      end
    end
    p_req[0] = 1'b0; l_req[0] = 1'b0;
    tick();
    check("rr_nacks",   32'(nacks), 32'd4);
    check("rr_order",   32'(seq),   32'b0101);
    check("rr_both",    32'(both),  32'd0);
    check("rr_p_rdata", p_rdata[0], 32'hDEADBEEF);
    check("rr_l_rdata", l_rdata[0], 32'h1);

    // Reset while instance 1 is in WAIT and instance 0 is in ISSUE of a write
    p_req[1] = 1'b1; p_wren[1] = 1'b0; p_addr[1] = 12'h010;
    tick();
    p_req[0] = 1'b1; p_wren[0] = 1'b1; p_addr[0] = 12'h200; p_wdata[0] = 32'h55;
    tick();
    check("pre_rst_wren0", 32'(mem_wren[0]), 32'd1);
    check("pre_rst_busy1", 32'(busy[1]),     32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy1",  32'(busy[1]),     32'd0);
    check("mid_rst_p_ack1", 32'(p_ack[1]),    32'd0);
    check("mid_rst_wren1",  32'(mem_wren[1]), 32'd0);
    check("mid_rst_owner1", 32'(owner[1]),    32'd1);
    check("mid_rst_wren0",  32'(mem_wren[0]), 32'd0);
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    access(1, 1'b0, 1'b0, 12'h010, 32'h0, lat, wr_cnt, wr_addr, rd, other);
    check("post_rst_lat",  32'(lat), 32'd4);
    check("post_rst_data", rd,       32'hDEADBEEF);

    // Address change during WAIT is ignored
    access(1, 1'b0, 1'b1, 12'h020, 32'h2020, lat, wr_cnt, wr_addr, rd, other);
    access(1, 1'b0, 1'b1, 12'h030, 32'h3030, lat, wr_cnt, wr_addr, rd, other);
    p_req[1] = 1'b1; p_wren[1] = 1'b0; p_addr[1] = 12'h020;
    tick();
    tick();
    p_addr[1] = 12'h030;
    tick();
    check("wait_addr_held", 32'(mem_addr[1]), 32'h020);
    n0 = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (p_ack[1] === 1'b1) begin
        n0 = n;
        rd = p_rdata[1];
        break;
      end
    end
    p_req[1] = 1'b0;
    tick();
    check("addr_chg_lat",  32'(n0 + 3), 32'd4);
    check("addr_chg_data", rd,          32'h2020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
